apb_regfile_ws: RTL and testbench
=================================

Name: apb_regfile_ws

Overview:
Parametrised APB3/APB4 completer register file, the next generation of the team's single-width APB peripheral. Data width, register count and wait-state count are configurable. Byte-lane writes, read-only register protection and address-decode errors are supported. The block sits behind the APB requester on the peripheral bus, drives registered PREADY/PRDATA/PSLVERR, and exposes the register contents to local logic.

Parameters:
DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16, 32 or 64
ADDR_WIDTH, 12, PADDR width
NUM_REGS, 16, number of DATA_WIDTH registers; at least 1
WAIT_STATES, 0, PREADY-low cycles inserted per transfer; range 0..15
RO_MASK, '0, NUM_REGS-bit mask; bit i set means register i is read-only

Ports:
pclk  in  1  APB clock
preset  in  1  asynchronous reset, active-high
psel  in  1  completer select
penable  in  1  access phase
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_WIDTH  byte address
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  byte-lane strobes
pready  out  1  transfer complete
prdata  out  DATA_WIDTH  read data
pslverr  out  1  transfer error
regs_o  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Clock and reset: one clock, pclk. Reset preset is asynchronous and active-high.
- Reset values: all registers, pready, prdata and pslverr = 0. State = IDLE.
- ALIGN = $clog2(DATA_WIDTH/8). Register index = paddr[ALIGN +: $clog2(NUM_REGS)].
- FSM states: IDLE, WAIT, READY. All outputs are registered and take effect on the cycle after the transition edge.
- IDLE:
  - Setup (psel=1, penable=0) latches the index, pwrite and the error flag.
  - Counter loads WAIT_STATES. Next state = WAIT if WAIT_STATES>0, else READY.
  - psel=1 with penable=1 while in IDLE is a protocol error. The flag is latched and the FSM still proceeds.
- WAIT:
  - pready=0, counter decrements each cycle.
  - At counter==1, next state = READY.
- READY:
  - pready=1 for exactly one cycle, then IDLE.
  - A back-to-back setup in the following cycle is accepted with no bubble.
- Abort: psel=0 in WAIT or READY sends the FSM to IDLE, drops pready, and suppresses the write.
- Error flag is set by any of:
  - paddr[ALIGN-1:0] != 0
  - index >= NUM_REGS, or paddr above the decoded range
  - write to a RO_MASK register
  - protocol error
- On an error, pslverr=1 and prdata=0 in READY. No register is modified.
- Write commit: on the READY-cycle edge when psel, penable and pwrite are all 1 and there is no error. Only lanes with pstrb[b]=1 are updated. pwdata is sampled at this edge.
- Read: prdata is loaded with reg[index] on the edge entering READY. prdata is 0 in every other cycle (never Z).
- Zero-wait timing: setup cycle T0, then pready=1 in T1. With N wait states, pready=1 in cycle T(1+N).
- Reset mid-transfer: immediate return to IDLE with outputs cleared. The pending write is lost.

Optional Feature:
Macro APB_PSTRB_EN.
- Defined: byte-lane writes per pstrb as described above. A write with pstrb=0 is legal and leaves the register unchanged.
- Undefined: pstrb is ignored and every error-free write updates the full word.

Decomposition:
- apb_pkg gains:
  - apb_ws_state_e enum {IDLE, WAIT, READY}
  - function validAlign generalised by ALIGN
  - localparam MAX_WAIT=15
- One sub-module, apb_ws_counter: load, decrement and done flag, with width $clog2(MAX_WAIT+1).

Test Plan:
1. WAIT_STATES=0: write 0xDEADBEEF to 0x004, then read 0x004 -> pready high in cycle T1 of each transfer, prdata=0xDEADBEEF, pslverr=0.
2. WAIT_STATES=3: read 0x008 -> pready low for 3 access cycles and high in the 4th; prdata valid only in that cycle.
3. With APB_PSTRB_EN: reg 2 = 0x11223344, write 0xAABBCCDD with pstrb=4'b0101 -> readback 0x11BB33DD. Without the macro -> 0xAABBCCDD.
4. Errors: read 0x002 (unaligned), read 0x040 with NUM_REGS=16, write to reg 0 with RO_MASK[0]=1 -> pslverr=1 and prdata=0 each time; reg 0 unchanged.
5. Abort and reset: with WAIT_STATES=3, drop psel after 1 wait cycle of a write to 0x00C -> reg 3 unchanged and FSM back in IDLE. Assert preset mid-WAIT -> all outputs 0 next cycle.
6. Back-to-back: writes to 0x000, 0x004, 0x008 with no idle cycles between them -> three completions; regs_o shows all three values.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and helpers for the wait-state APB register file.
//   apb_ws_state_e : completer FSM states (IDLE, WAIT, READY)
//   MAX_WAIT       : largest supported wait-state count
//   validAlign     : true when the low `align` address bits are zero
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_ws_state_e;

  localparam int MAX_WAIT = 15;

  function automatic logic validAlign(input logic [63:0] addr, input int align);
    logic [63:0] m;
    m = (64'd1 << align) - 64'd1;
    return (addr & m) == 64'd0;
  endfunction

endpackage

// File: rtl/apb_ws_counter.sv
// apb_ws_counter: wait-state down counter.
//   i_clk, i_rst   : clock, async active-high reset
//   i_load         : load i_load_val (takes priority over decrement)
//   i_load_val     : wait-state count to load
//   i_dec          : decrement by one (saturates at zero)
//   o_done         : count has reached 1, i.e. this is the last wait cycle
module apb_ws_counter
  import apb_pkg::*;
#(
  parameter int CNT_W = $clog2(MAX_WAIT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                     r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/apb_regfile_ws.sv
// apb_regfile_ws: APB3/APB4 completer register file with configurable
// wait states, byte-lane writes, read-only registers and decode errors.
//   pclk, preset       : clock, async active-high reset
//   psel/penable/pwrite/paddr/pwdata/pstrb : APB requester inputs
//   pready/prdata/pslverr : registered APB responses
//   regs_o             : flattened register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// Macro APB_PSTRB_EN: when defined, writes update only lanes with pstrb set;
// when undefined, pstrb is ignored and every good write updates the full word.
module apb_regfile_ws
  import apb_pkg::*;
#(
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  ADDR_WIDTH  = 12,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int ALIGN = $clog2(NB);
  // A single-register file still needs one index bit so stray addresses decode as errors.
  localparam int IDXW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WS_L = CNT_W'(WAIT_STATES);
  localparam logic [IDXW:0]    NR_L = (IDXW + 1)'(NUM_REGS);

  apb_ws_state_e         r_state, w_next;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [IDXW-1:0]       r_idx, w_idx, w_idx_sel;
  logic                  r_err, w_err, w_err_sel;
  logic                  r_write, w_write_sel;
  logic                  w_ro, w_load, w_dec, w_done, w_enter_rdy, w_commit;
  logic [DATA_WIDTH-1:0] w_rd;
  logic [NB-1:0]         w_strb;

`ifdef APB_PSTRB_EN
  assign w_strb = pstrb;
`else
  // Strobes are ignored: every error-free write covers the whole word.
  assign w_strb = pstrb | '1;
`endif

  // Setup-phase decode
  assign w_idx = IDXW'(paddr >> ALIGN);

  always_comb begin
    w_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_idx == IDXW'(i) && RO_MASK[i]) w_ro = 1'b1;
  end

  // penable already high in IDLE is a protocol error; the transfer still runs.
  assign w_err = !validAlign(64'(paddr), ALIGN)
               || ({1'b0, w_idx} >= NR_L)
               || ((paddr >> (ALIGN + IDXW)) != '0)
               || (pwrite && w_ro)
               || penable;

  // With zero wait states READY is entered straight from IDLE, before the
  // setup fields are latched, so the live decode is used there.
  assign w_idx_sel   = (r_state == IDLE) ? w_idx  : r_idx;
  assign w_err_sel   = (r_state == IDLE) ? w_err  : r_err;
  assign w_write_sel = (r_state == IDLE) ? pwrite : r_write;

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_idx_sel == IDXW'(i)) w_rd = r_regs[i];
  end

  apb_ws_counter #(.CNT_W(CNT_W)) u_cnt (
    .i_clk      (pclk),
    .i_rst      (preset),
    .i_load     (w_load),
    .i_load_val (WS_L),
    .i_dec      (w_dec),
    .o_done     (w_done)
  );

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      IDLE: if (psel) begin
        w_load = 1'b1;
        w_next = (WAIT_STATES > 0) ? WAIT : READY;
      end
      WAIT: begin
        if (!psel) w_next = IDLE;
        else begin
          w_dec = 1'b1;
          if (w_done) w_next = READY;
        end
      end
      READY:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_enter_rdy = (w_next == READY);
  assign w_commit    = (r_state == READY) && psel && penable && pwrite && r_write && !r_err;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_write <= 1'b0;
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && psel) begin
        r_idx   <= w_idx;
        r_err   <= w_err;
        r_write <= pwrite;
      end
      pready  <= w_enter_rdy;
      pslverr <= w_enter_rdy && w_err_sel;
      prdata  <= (w_enter_rdy && !w_err_sel && !w_write_sel) ? w_rd : '0;
      for (int i = 0; i < NUM_REGS; i++)
        for (int b = 0; b < NB; b++)
          if (w_commit && r_idx == IDXW'(i) && w_strb[b])
            r_regs[i][b*8 +: 8] <= pwdata[b*8 +: 8];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

endmodule

// File: tb/tb_apb_regfile_ws.sv
// Bench for apb_regfile_ws: two instances on one clock, index 0 with no wait
// states and register 0 read-only, index 1 with three wait states.
module tb_apb_regfile_ws;

  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  logic         psel [2], penable [2], pwrite [2];
  logic [11:0]  paddr [2];
  logic [31:0]  pwdata [2];
  logic [3:0]   pstrb [2];
  logic         pready [2], pslverr [2];
  logic [31:0]  prdata [2];
  logic [511:0] regs_o [2];

  apb_regfile_ws #(.WAIT_STATES(0), .RO_MASK(16'h0001)) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
    .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]), .regs_o(regs_o[0]));

  apb_regfile_ws #(.WAIT_STATES(3)) u_dut1 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
    .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]), .regs_o(regs_o[1]));

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  typedef struct {
    int          d;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int waits(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  // Called just after a rising edge; returns just after the edge that ends
  // the READY cycle, with the bus idle, so a following call is back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [11:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input logic bad_setup);
    exp_t e;
    int   n;
    psel[d] = 1'b1; penable[d] = bad_setup; pwrite[d] = wr;
    paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    sb.push_back('{rd: exp_rd, err: exp_err});
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    n = 0;
    forever begin
      @(negedge pclk);
      if (pready[d]) break;
      chk($sformatf("prdata_wait a=%h", a), prdata[d], 32'h0);
      n++;
      if (n > 20) begin
        checks++; failures++;
        $display("FAIL timeout a=%h actual=no_pready required=pready", a);
        break;
      end
      @(posedge pclk); #1;
    end
    e = sb.pop_front();
    if (n <= 20) begin
      chk($sformatf("wait_cycles a=%h", a), 32'(n), 32'(waits(d)));
      chk($sformatf("prdata a=%h", a), prdata[d], e.rd);
      chk($sformatf("pslverr a=%h", a), 32'(pslverr[d]), 32'(e.err));
    end
    @(posedge pclk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  logic [31:0] strb_exp;

  initial begin
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
    end
`ifdef APB_PSTRB_EN
    strb_exp = 32'h11BB33DD;
`else
    strb_exp = 32'hAABBCCDD;
`endif
    //                d  wr  addr     wdata          strb  rdata         err
    tbl.push_back('{0, 1, 12'h004, 32'hDEADBEEF, 4'hF, 32'h0,        0});
    tbl.push_back('{0, 0, 12'h004, 32'h0,        4'hF, 32'hDEADBEEF, 0});
    tbl.push_back('{0, 1, 12'h008, 32'h11223344, 4'hF, 32'h0,        0});
    tbl.push_back('{0, 1, 12'h008, 32'hAABBCCDD, 4'h5, 32'h0,        0});
    tbl.push_back('{0, 0, 12'h008, 32'h0,        4'hF, strb_exp,     0});
    tbl.push_back('{0, 0, 12'h002, 32'h0,        4'hF, 32'h0,        1});
    tbl.push_back('{0, 0, 12'h040, 32'h0,        4'hF, 32'h0,        1});
    tbl.push_back('{0, 0, 12'h800, 32'h0,        4'hF, 32'h0,        1});
    tbl.push_back('{0, 1, 12'h000, 32'h12345678, 4'hF, 32'h0,        1});
    tbl.push_back('{0, 0, 12'h000, 32'h0,        4'hF, 32'h0,        0});
    tbl.push_back('{0, 1, 12'h03C, 32'hCAFEF00D, 4'hF, 32'h0,        0});
    tbl.push_back('{0, 0, 12'h03C, 32'h0,        4'hF, 32'hCAFEF00D, 0});
    tbl.push_back('{1, 1, 12'h008, 32'h55AA55AA, 4'hF, 32'h0,        0});
    tbl.push_back('{1, 0, 12'h008, 32'h0,        4'hF, 32'h55AA55AA, 0});

    preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_pready", 32'(pready[d]), 32'h0);
      chk("reset_prdata", prdata[d], 32'h0);
      chk("reset_pslverr", 32'(pslverr[d]), 32'h0);
      chk("reset_regs", regs_o[d][31:0] | regs_o[d][95:64], 32'h0);
    end
    @(posedge pclk); #1;

    for (int i = 0; i < tbl.size(); i++)
      xfer(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].st, tbl[i].rd, tbl[i].err, 1'b0);
    chk("reg0_ro_unchanged", regs_o[0][31:0], 32'h0);
    chk("reg2_regs_o", regs_o[0][95:64], strb_exp);

    // penable already high at the first cycle: error, but still completes
    xfer(0, 1'b0, 12'h004, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);

    // Abort a write to reg 3 after one wait cycle
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 12'h00C;
    pwdata[1] = 32'h0BADF00D; pstrb[1] = 4'hF;
    @(posedge pclk); #1 penable[1] = 1;
    @(posedge pclk); #1 begin psel[1] = 0; penable[1] = 0; end
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      chk("abort_pready", 32'(pready[1]), 32'h0);
    end
    chk("abort_reg3", regs_o[1][127:96], 32'h0);
    @(posedge pclk); #1;
    xfer(1, 1'b0, 12'h00C, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);

    // Reset in the middle of a wait sequence
    psel[1] = 1; penable[1] = 0; pwrite[1] = 0; paddr[1] = 12'h008;
    @(posedge pclk); #1 penable[1] = 1;
    @(posedge pclk); #2 preset = 1'b1;
    #1;
    chk("async_rst_regs", regs_o[1][95:64], 32'h0);
    chk("async_rst_pready", 32'(pready[1]), 32'h0);
    @(negedge pclk);
    chk("rst_prdata", prdata[1], 32'h0);
    chk("rst_pslverr", 32'(pslverr[1]), 32'h0);
    chk("rst_reg_dut0", regs_o[0][63:32], 32'h0);
    psel[1] = 0; penable[1] = 0;
    @(posedge pclk); #1 preset = 1'b0;
    xfer(1, 1'b0, 12'h008, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);

    // Back-to-back writes, no idle cycles between transfers
    xfer(1, 1'b1, 12'h000, 32'hA0A0A0A0, 4'hF, 32'h0, 1'b0, 1'b0);
    xfer(1, 1'b1, 12'h004, 32'hB1B1B1B1, 4'hF, 32'h0, 1'b0, 1'b0);
    xfer(1, 1'b1, 12'h008, 32'hC2C2C2C2, 4'hF, 32'h0, 1'b0, 1'b0);
    chk("b2b_ws_reg0", regs_o[1][31:0],  32'hA0A0A0A0);
    chk("b2b_ws_reg1", regs_o[1][63:32], 32'hB1B1B1B1);
    chk("b2b_ws_reg2", regs_o[1][95:64], 32'hC2C2C2C2);
    xfer(0, 1'b1, 12'h004, 32'h01010101, 4'hF, 32'h0, 1'b0, 1'b0);
    xfer(0, 1'b1, 12'h008, 32'h02020202, 4'hF, 32'h0, 1'b0, 1'b0);
    xfer(0, 1'b1, 12'h00C, 32'h03030303, 4'hF, 32'h0, 1'b0, 1'b0);
    chk("b2b_zw_reg1", regs_o[0][63:32],  32'h01010101);
    chk("b2b_zw_reg2", regs_o[0][95:64],  32'h02020202);
    chk("b2b_zw_reg3", regs_o[0][127:96], 32'h03030303);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
